// File: rtl/hdr_pkg.sv
// ---------------------------------------------------------------------------
// hdr_pkg
//   Shared types and default constants for the HDR gain combiner.
//   - gain_state_t : FSM encoding, also exported on the gain_state port.
//   - *_DEF        : default parameter values used by the combiner and
//                    its crossfade sub-module.
// ---------------------------------------------------------------------------
package hdr_pkg;

  localparam int DATA_W_DEF      = 9;  // signed HG/LG sample width
  localparam int GAIN_SHIFT_DEF  = 4;  // log2 of LG-to-HG gain ratio
  localparam int ALPHA_DELAY_DEF = 2;  // alpha alignment, in strobes
  localparam int XF_LOG2_DEF     = 2;  // log2 of crossfade length N

  typedef enum logic [1:0] {
    HG    = 2'd0,  // high-gain channel only, k = 0
    XF_UP = 2'd1,  // crossfading towards LG
    LG    = 2'd2,  // low-gain channel only, k = N
    XF_DN = 2'd3   // crossfading towards HG
  } gain_state_t;

endpackage : hdr_pkg

// File: rtl/hdr_xfade_weight.sv
// ---------------------------------------------------------------------------
// hdr_xfade_weight
//   Combinational linear crossfade between the HG sample and the LG sample
//   rescaled to HG units:
//     hdr_out = (h*(N-k) + l*k) >>> XF_LOG2
//   with h = sext(hg), l = sext(lg) <<< GAIN_SHIFT, N = 2**XF_LOG2.
//   The sum of weights is N, so the result always fits OUT_W bits.
// Ports
//   hg_sample  in   DATA_W          signed HG sample
//   lg_sample  in   DATA_W          signed LG sample
//   k          in   XF_LOG2+1       LG weight, 0..N
//   hdr_out    out  DATA_W+GAIN_SHIFT  signed blended sample, HG units
// ---------------------------------------------------------------------------
module hdr_xfade_weight
  import hdr_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF,
  parameter int XF_LOG2    = XF_LOG2_DEF
) (
  input  logic signed [DATA_W-1:0]            hg_sample,
  input  logic signed [DATA_W-1:0]            lg_sample,
  input  logic        [XF_LOG2:0]             k,
  output logic signed [DATA_W+GAIN_SHIFT-1:0] hdr_out
);

  localparam int OUT_W = DATA_W + GAIN_SHIFT;
  // One extra bit over OUT_W+XF_LOG2 keeps the signed weighted sum exact.
  localparam int ACC_W = OUT_W + XF_LOG2 + 1;
  localparam int N     = 1 << XF_LOG2;

  logic signed [ACC_W-1:0] h;
  logic signed [ACC_W-1:0] l;
  logic signed [ACC_W-1:0] w_lg;
  logic signed [ACC_W-1:0] w_hg;
  logic signed [ACC_W-1:0] acc;

  assign h    = ACC_W'(hg_sample);
  assign l    = ACC_W'(lg_sample) <<< GAIN_SHIFT;
  assign w_lg = ACC_W'(k);          // k is unsigned, so this zero-extends
  assign w_hg = ACC_W'(N) - w_lg;
  assign acc  = h * w_hg + l * w_lg;

  // Arithmetic shift of a signed value: rounds toward minus infinity.
  assign hdr_out = OUT_W'(acc >>> XF_LOG2);

endmodule : hdr_xfade_weight

// File: rtl/hdr_gain_combiner.sv
// ---------------------------------------------------------------------------
// hdr_gain_combiner
//   Merges high-gain and low-gain channel samples into one HDR stream.
//   The alpha gain decision is delayed ALPHA_DELAY strobes to line up with
//   the data path; on every gain switch the output crossfades linearly over
//   N = 2**XF_LOG2 strobes so downstream sees no step. Everything advances
//   only on cycles with enable_sampling high.
// Ports
//   clk              in   1        system clock
//   reset            in   1        synchronous, active-high reset
//   enable_sampling  in   1        sample strobe (may be held high)
//   alpha            in   1        1 = large signal, prefer LG; 0 = prefer HG
//   hg_sample        in   DATA_W   signed HG sample, valid on strobe
//   lg_sample        in   DATA_W   signed LG sample, valid on strobe
//   hdr_out          out  OUT_W    signed combined sample, HG units
//   hdr_valid        out  1        pulse: hdr_out updated
//   gain_state       out  2        current FSM state
//   switch_event     out  1        pulse with hdr_valid when a crossfade
//                                  starts from a settled HG/LG state
// ---------------------------------------------------------------------------
module hdr_gain_combiner
  import hdr_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int GAIN_SHIFT  = GAIN_SHIFT_DEF,
  parameter int ALPHA_DELAY = ALPHA_DELAY_DEF,
  parameter int XF_LOG2     = XF_LOG2_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable_sampling,
  input  logic                                alpha,
  input  logic signed [DATA_W-1:0]            hg_sample,
  input  logic signed [DATA_W-1:0]            lg_sample,
  output logic signed [DATA_W+GAIN_SHIFT-1:0] hdr_out,
  output logic                                hdr_valid,
  output gain_state_t                         gain_state,
  output logic                                switch_event
);

  localparam int OUT_W = DATA_W + GAIN_SHIFT;
  localparam int K_W   = XF_LOG2 + 1;
  localparam int N     = 1 << XF_LOG2;

  localparam logic [K_W-1:0] K_ZERO = '0;
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic [K_W-1:0] K_FULL = K_W'(N);
  localparam logic [K_W-1:0] K_NM1  = K_W'(N - 1);

  // -------------------------------------------------------------------------
  // Alpha alignment: a_d is the decision taken ALPHA_DELAY strobes ago.
  // -------------------------------------------------------------------------
  logic a_d;

  if (ALPHA_DELAY == 0) begin : g_no_delay
    assign a_d = alpha;
  end else begin : g_delay
    logic [ALPHA_DELAY-1:0] alpha_dly_q;
    logic [ALPHA_DELAY-1:0] alpha_dly_d;

    // NOTE: every signal assigned in an always_comb gets a default on the
    // first line, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
      alpha_dly_d = alpha_dly_q;
      if (enable_sampling) begin
        alpha_dly_d = (alpha_dly_q << 1) | ALPHA_DELAY'(alpha);
      end
    end

    // NOTE: the delay line is a handful of flops, not a RAM, so it is reset
    // like any other state; clearing it makes the first decision after
    // reset "HG" regardless of what alpha did before.
    always_ff @(posedge clk) begin
      if (reset) begin
        alpha_dly_q <= '0;
      end else begin
        alpha_dly_q <= alpha_dly_d;
      end
    end

    assign a_d = alpha_dly_q[ALPHA_DELAY-1];
  end

  // -------------------------------------------------------------------------
  // Gain FSM and crossfade weight k (LG weight, 0..N).
  // -------------------------------------------------------------------------
  gain_state_t    state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic           switch_d;
  logic [K_W-1:0] k_inc;
  logic [K_W-1:0] k_dec;

  assign k_inc = k_q + K_ONE;
  assign k_dec = k_q - K_ONE;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    switch_d = 1'b0;
    if (enable_sampling) begin
      unique case (state_q)
        HG: begin
          if (a_d) begin
            k_d      = K_ONE;
            state_d  = (N == 1) ? LG : XF_UP;
            switch_d = 1'b1;
          end else begin
            k_d = K_ZERO;
          end
        end
        XF_UP: begin
          // A reversal keeps k and only turns the direction around.
          if (a_d) begin
            k_d     = k_inc;
            state_d = (k_inc == K_FULL) ? LG : XF_UP;
          end else begin
            k_d     = k_dec;
            state_d = (k_dec == K_ZERO) ? HG : XF_DN;
          end
        end
        LG: begin
          if (!a_d) begin
            k_d      = K_NM1;
            state_d  = (N == 1) ? HG : XF_DN;
            switch_d = 1'b1;
          end else begin
            k_d = K_FULL;
          end
        end
        XF_DN: begin
          if (!a_d) begin
            k_d     = k_dec;
            state_d = (k_dec == K_ZERO) ? HG : XF_DN;
          end else begin
            k_d     = k_inc;
            state_d = (k_inc == K_FULL) ? LG : XF_UP;
          end
        end
        default: begin
          state_d = HG;
          k_d     = K_ZERO;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: the blend uses the k chosen for this very strobe.
  // -------------------------------------------------------------------------
  logic signed [OUT_W-1:0] xf_out;
  logic signed [OUT_W-1:0] hdr_q, hdr_d;
  logic                    valid_q, valid_d;
  logic                    switch_q;

  hdr_xfade_weight #(
    .DATA_W    (DATA_W),
    .GAIN_SHIFT(GAIN_SHIFT),
    .XF_LOG2   (XF_LOG2)
  ) u_xfade (
    .hg_sample(hg_sample),
    .lg_sample(lg_sample),
    .k        (k_d),
    .hdr_out  (xf_out)
  );

  // Kept apart from the FSM block: k_d feeds the blend and the blend feeds
  // hdr_d, so one block would read its own output combinationally.
  always_comb begin
    hdr_d   = hdr_q;
    valid_d = enable_sampling;
    if (enable_sampling) begin
      hdr_d = xf_out;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= HG;
      k_q      <= K_ZERO;
      hdr_q    <= '0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      hdr_q    <= hdr_d;
      valid_q  <= valid_d;
      switch_q <= switch_d;
    end
  end

  assign hdr_out      = hdr_q;
  assign hdr_valid    = valid_q;
  assign gain_state   = state_q;
  assign switch_event = switch_q;

endmodule : hdr_gain_combiner
